// File: rtl/answer_entry_bcd.sv
// Two-digit BCD answer entry: synchronised, debounced Enter/Clear buttons feed a
// TENS -> UNITS -> HOLD entry FSM that offers tens*10+units over valid/ready.
module answer_entry_bcd #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEB_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_en,
  input  logic [3:0] digit_sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [6:0] answer,
  output logic       ans_valid,
  input  logic       ans_ready,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_units,
  output logic [1:0] entry_state,
  output logic       digit_err
);

  typedef enum logic [1:0] {
    ST_TENS  = 2'b00,
    ST_UNITS = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  // tens*10 + units using shifts only; 9*10+9 fits in 7 bits
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] u);
    logic [6:0] t7;
    t7 = {3'b000, t};
    return (t7 << 3'd3) + (t7 << 3'd1) + {3'b000, u};
  endfunction

  // bit 0 = Enter, bit 1 = Clear
  logic [1:0]            sync1_r, sync2_r, deb_r, deb_q_r;
  logic [1:0][DEB_W-1:0] cnt_r;
  logic [1:0]            evt_s;
  logic                  enter_evt_s, clear_evt_s, digit_ok_s;

  state_t     state_r, state_n;
  logic [3:0] tens_r, tens_n, units_r, units_n;
  logic [3:0] disp_tens_r, disp_units_r;
  logic [6:0] answer_r, answer_n;
  logic       valid_r, valid_n, err_r, err_n;

  // Button synchronisers and per-button debounce counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      deb_r   <= 2'b00;
      deb_q_r <= 2'b00;
      cnt_r   <= '0;
    end else begin
      sync1_r <= {btn_clear, btn_enter};
      sync2_r <= sync1_r;
      deb_q_r <= deb_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (cnt_r[i] == DEB_LAST) begin
            deb_r[i] <= sync2_r[i];
            cnt_r[i] <= '0;
          end else begin
            cnt_r[i] <= cnt_r[i] + DEB_W'(1);
          end
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  // Rising edge of the debounced level only; release is silent
  assign evt_s       = deb_r & ~deb_q_r;
  assign enter_evt_s = evt_s[0] & entry_en;
  assign clear_evt_s = evt_s[1] & entry_en;
  assign digit_ok_s  = (digit_sw <= 4'd9);

  // Entry FSM next-state; Clear has priority over Enter
  always_comb begin
    state_n  = state_r;
    tens_n   = tens_r;
    units_n  = units_r;
    answer_n = answer_r;
    valid_n  = valid_r;
    err_n    = 1'b0;
    case (state_r)
      ST_TENS: begin
        if (clear_evt_s) begin
          tens_n  = 4'd0;
          units_n = 4'd0;
        end else if (enter_evt_s) begin
          if (digit_ok_s) begin
            tens_n  = digit_sw;
            state_n = ST_UNITS;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          state_n = ST_TENS;
        end
      end
      ST_UNITS: begin
        if (clear_evt_s) begin
          tens_n  = 4'd0;
          state_n = ST_TENS;
        end else if (enter_evt_s) begin
          if (digit_ok_s) begin
            units_n  = digit_sw;
            answer_n = bcd_to_bin(tens_r, digit_sw);
            valid_n  = 1'b1;
            state_n  = ST_HOLD;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          state_n = ST_UNITS;
        end
      end
      ST_HOLD: begin
        // Buttons are ignored here; only the handshake leaves HOLD
        if (valid_r && ans_ready) begin
          valid_n = 1'b0;
          tens_n  = 4'd0;
          units_n = 4'd0;
          state_n = ST_TENS;
        end else begin
          state_n = ST_HOLD;
        end
      end
      default: begin
        state_n = ST_TENS;
        tens_n  = 4'd0;
        units_n = 4'd0;
        valid_n = 1'b0;
      end
    endcase
  end

  // Entry state, digit registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_TENS;
      tens_r       <= 4'd0;
      units_r      <= 4'd0;
      answer_r     <= 7'd0;
      valid_r      <= 1'b0;
      err_r        <= 1'b0;
      disp_tens_r  <= 4'd0;
      disp_units_r <= 4'd0;
    end else begin
      state_r      <= state_n;
      tens_r       <= tens_n;
      units_r      <= units_n;
      answer_r     <= answer_n;
      valid_r      <= valid_n;
      err_r        <= err_n;
      disp_tens_r  <= (state_n == ST_TENS) ? 4'd0 : tens_n;
      disp_units_r <= (state_n == ST_HOLD) ? units_n : 4'd0;
    end
  end

  assign answer      = answer_r;
  assign ans_valid   = valid_r;
  assign digit_err   = err_r;
  assign disp_tens   = disp_tens_r;
  assign disp_units  = disp_units_r;
  assign entry_state = state_r;

endmodule
